// File: rtl/frame_capture_ctrl_if.sv
// Control/status bundle between the frame capture controller and its writer/consumer.
// master: the controller; slave: the writer/consumer side driving the handshakes.
interface frame_capture_ctrl_if #(
    parameter int unsigned ADDR_W  = 23,
    parameter int unsigned NUM_BUF = 2
);
    localparam int unsigned CNT_W  = $clog2(NUM_BUF + 1);
    localparam int unsigned DROP_W = 16;

    logic              start;
    logic              continuous;
    logic              almost_done_wr;
    logic              rd_done;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] max_wr;
    logic [ADDR_W-1:0] rd_addr;
    logic              frame_valid;
    logic [CNT_W-1:0]  fill_cnt;
    logic              busy;
    logic [DROP_W-1:0] drop_cnt;

    modport master (
        input  start, continuous, almost_done_wr, rd_done,
        output wr_addr, max_wr, rd_addr, frame_valid, fill_cnt, busy, drop_cnt
    );

    modport slave (
        output start, continuous, almost_done_wr, rd_done,
        input  wr_addr, max_wr, rd_addr, frame_valid, fill_cnt, busy, drop_cnt
    );
endinterface

// File: rtl/frame_capture_ctrl.sv
// Ring-buffer frame capture controller: hands out write/read frame bases over NUM_BUF buffers.
// Optional overwrite counter enabled by defining FRAME_CAPTURE_DROP_CNT_EN.
module frame_capture_ctrl #(
    parameter int unsigned H_RES   = 640,
    parameter int unsigned V_RES   = 480,
    parameter int unsigned NUM_BUF = 2,
    parameter int unsigned ADDR_W  = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    frame_capture_ctrl_if.master bus
);
    localparam int unsigned FRAME  = H_RES * V_RES;
    localparam int unsigned CNT_W  = $clog2(NUM_BUF + 1);
    localparam int unsigned DROP_W = 16;

    localparam logic [ADDR_W-1:0] FRAME_A   = ADDR_W'(FRAME);
    localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'((NUM_BUF - 1) * FRAME);
    localparam logic [CNT_W-1:0]  FULL      = CNT_W'(NUM_BUF);
    localparam logic [DROP_W-1:0] DROP_MAX  = {DROP_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              mode_q, mode_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] max_wr_q, max_wr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]  fill_q, fill_d;
    logic              frame_valid_q;
    logic              busy_q;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              wr_evt, rd_evt, wr_adv;

    // Next-state, ring bookkeeping and next output values
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        fill_d    = fill_q;
        drop_d    = drop_q;

        wr_evt = (state_q == S_CAPTURE) && bus.almost_done_wr;
        rd_evt = bus.rd_done && (fill_q != '0);
        // A release in the same cycle frees a slot, so a full ring can still advance
        wr_adv = wr_evt && ((fill_q < FULL) || rd_evt);

        if (wr_adv) begin
            wr_addr_d = (wr_addr_q == LAST_BASE) ? '0 : wr_addr_q + FRAME_A;
        end
        if (rd_evt) begin
            rd_addr_d = (rd_addr_q == LAST_BASE) ? '0 : rd_addr_q + FRAME_A;
        end

        if (wr_adv && !rd_evt) begin
            fill_d = fill_q + CNT_W'(1);
        end else if (!wr_adv && rd_evt) begin
            fill_d = fill_q - CNT_W'(1);
        end

`ifdef FRAME_CAPTURE_DROP_CNT_EN
        if (wr_evt && !wr_adv && (drop_q != DROP_MAX)) begin
            drop_d = drop_q + DROP_W'(1);
        end
`endif

        max_wr_d = wr_addr_d + FRAME_A;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_CAPTURE;
                    mode_d  = bus.continuous;
                end
            end
            S_CAPTURE: begin
                if (wr_evt && (!mode_q || !bus.start)) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!bus.start && (fill_d == '0)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            mode_q        <= 1'b0;
            wr_addr_q     <= '0;
            max_wr_q      <= FRAME_A;
            rd_addr_q     <= '0;
            fill_q        <= '0;
            frame_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            drop_q        <= '0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            wr_addr_q     <= wr_addr_d;
            max_wr_q      <= max_wr_d;
            rd_addr_q     <= rd_addr_d;
            fill_q        <= fill_d;
            frame_valid_q <= (fill_d != '0);
            busy_q        <= (state_d != S_IDLE);
            drop_q        <= drop_d;
        end
    end

    assign bus.wr_addr     = wr_addr_q;
    assign bus.max_wr      = max_wr_q;
    assign bus.rd_addr     = rd_addr_q;
    assign bus.fill_cnt    = fill_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.busy        = busy_q;
`ifdef FRAME_CAPTURE_DROP_CNT_EN
    assign bus.drop_cnt    = drop_q;
`else
    assign bus.drop_cnt    = '0;
`endif

endmodule
